// File: rtl/alu_pipe_hs.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_hs
//  Description : Registered ALU with valid/ready handshakes on both sides.
//                Seven single-cycle ops plus an unsigned shift-add multiply
//                that runs one step per cycle for WIDTH cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_pipe_hs #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [SHW-1:0] STEP_LAST = SHW'(WIDTH - 1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             accept;
  logic             accept_mul;
  logic             mul_last;

  // Multiplier working registers: multiplicand and the {hi,lo} product pair,
  // where lo starts as the multiplier and is consumed one bit per step.
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  logic [SHW-1:0]   step_cnt;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // Single-cycle datapath
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH:0]   shl_full;
  logic [WIDTH:0]   shr_full;
  logic [WIDTH-1:0] alu_out;
  logic             alu_c;
  logic             alu_v;

  assign accept     = in_valid & in_ready;
  assign accept_mul = accept & (func == OP_MUL);

  // Single-cycle op results; shifts are widened by one bit so the last bit
  // shifted out lands in the extra position (zero when the amount is zero).
  always_comb begin
    shamt    = b[SHW-1:0];
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} - {1'b0, b};
    shl_full = {1'b0, a} << shamt;
    shr_full = {a, 1'b0} >> shamt;
    alu_out  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (func)
      OP_ADD: begin
        alu_out = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_out = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_out = a & b;
      OP_OR:  alu_out = a | b;
      OP_XOR: alu_out = a ^ b;
      OP_SHL: begin
        alu_out = shl_full[WIDTH-1:0];
        alu_c   = shl_full[WIDTH];
      end
      OP_SHR: begin
        alu_out = shr_full[WIDTH:1];
        alu_c   = shr_full[0];
      end
      default: alu_out = '0;
    endcase
  end

  // One shift-add step: add multiplicand if the current multiplier bit is set,
  // then shift the whole {sum, lo} pair right by one.
  always_comb begin
    step_sum = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    step_hi  = step_sum[WIDTH:1];
    step_lo  = {step_sum[0], prod_lo[WIDTH-1:1]};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept_mul) state_nxt = ST_BUSY;
      ST_BUSY: if (step_cnt == STEP_LAST) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only when idle and the output slot is free or draining
  always_comb begin
    in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    mul_last = (state == ST_BUSY) && (step_cnt == STEP_LAST);
  end

  // Multiplier sequencer: load operands on accept, step once per busy cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand    <= '0;
      prod_hi  <= '0;
      prod_lo  <= '0;
      step_cnt <= '0;
    end else if (accept_mul) begin
      mcand    <= a;
      prod_hi  <= '0;
      prod_lo  <= b;
      step_cnt <= '0;
    end else if (state == ST_BUSY) begin
      prod_hi  <= step_hi;
      prod_lo  <= step_lo;
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // Output register: loads with a new result, otherwise holds until drained
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_hi    <= '0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
    end else if (accept && !accept_mul) begin
      out_valid <= 1'b1;
      out       <= alu_out;
      out_hi    <= '0;
      flag_c    <= alu_c;
      flag_v    <= alu_v;
      flag_z    <= (alu_out == '0);
      flag_n    <= alu_out[WIDTH-1];
    end else if (mul_last) begin
      out_valid <= 1'b1;
      out       <= step_lo;
      out_hi    <= step_hi;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_z    <= ({step_hi, step_lo} == '0);
      flag_n    <= step_lo[WIDTH-1];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_hs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe_hs
//  Description : Self-checking bench for alu_pipe_hs: directed vectors plus
//                randomized traffic against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_pipe_hs;

  localparam int W = 16;
  localparam int S = 4;
  localparam longint LIM  = 64'sd1 << W;
  localparam longint SMAX = (64'sd1 << (W - 1)) - 1;
  localparam longint SMIN = -(SMAX + 1);

  typedef struct packed {
    logic [W-1:0] o;
    logic [W-1:0] h;
    logic c, v, z, n;
  } res_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready;
  logic [W-1:0] a, b;
  logic [2:0] func;
  logic in_ready, out_valid;
  logic [W-1:0] out, out_hi;
  logic flag_c, flag_v, flag_z, flag_n;

  int checks = 0;
  int passes = 0;
  bit chk_en = 0;

  // Model state
  int   m_busy = 0;
  bit   m_ov   = 0;
  bit   m_acc  = 0;
  bit   m_rdy  = 0;
  res_t m_cur  = '0;
  res_t m_pend = '0;

  alu_pipe_hs #(.WIDTH(W), .SHW(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .func(func), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi), .flag_c(flag_c), .flag_v(flag_v),
    .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  // Reference arithmetic from the op definitions
  function automatic res_t ref_alu(input logic [2:0] f, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    res_t q;
    longint ux, uy, sx, sy, r, t;
    int s;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s  = int'(y[S-1:0]);
    q  = '0;
    r  = 0;
    t  = 0;
    case (f)
      3'd0: begin r = ux + uy; q.c = (r >= LIM); t = sx + sy; q.v = (t > SMAX) || (t < SMIN); end
      3'd1: begin r = ux - uy; q.c = (ux < uy);  t = sx - sy; q.v = (t > SMAX) || (t < SMIN); end
      3'd2: r = ux & uy;
      3'd3: r = ux | uy;
      3'd4: r = ux ^ uy;
      3'd5: begin r = ux << s; q.c = (s != 0) && (((ux >> (W - s)) & 1) == 1); end
      3'd6: begin r = ux >> s; q.c = (s != 0) && (((ux >> (s - 1)) & 1) == 1); end
      default: begin r = ux * uy; q.h = W'(r >> W); end
    endcase
    q.o = W'(r);
    q.z = (q.o == '0) && (q.h == '0);
    q.n = q.o[W-1];
    return q;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passes++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    func = f;
    a = x;
    b = y;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Transaction-level model: one output slot plus a MUL countdown
  always @(posedge clk) begin
    m_acc = 0;
    if (!rst_n) begin
      m_busy = 0;
      m_ov   = 0;
      m_cur  = '0;
    end else begin
      m_rdy = (m_busy == 0) && (!m_ov || out_ready);
      m_acc = in_valid && m_rdy;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_cur = m_pend;
          m_ov  = 1;
        end
      end else if (m_acc && func == 3'd7) begin
        m_pend = ref_alu(func, a, b);
        m_busy = W;
        m_ov   = 0;
      end else if (m_acc) begin
        m_cur = ref_alu(func, a, b);
        m_ov  = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, (m_busy == 0) && (!m_ov || out_ready));
      chk("out_valid", out_valid, m_ov);
      chk("result", {out, out_hi, flag_c, flag_v, flag_z, flag_n}, m_cur);
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; func = '0;

    // Hand-computed values pinning the model
    chk("pin_add", ref_alu(3'd0, 16'd24050, 16'd53040), {16'd11554, 16'd0, 4'b1000});
    chk("pin_sub", ref_alu(3'd1, 16'd24050, 16'd53040), {16'd36546, 16'd0, 4'b1101});
    chk("pin_mul", ref_alu(3'd7, 16'd24050, 16'd53040), {16'd19296, 16'd19464, 4'b0000});
    chk("pin_shl", ref_alu(3'd5, 16'h8001, 16'd1), {16'h0002, 16'd0, 4'b1000});
    chk("pin_shr", ref_alu(3'd6, 16'h0003, 16'd1), {16'h0001, 16'd0, 4'b1000});
    chk("pin_sh0", ref_alu(3'd5, 16'h8000, 16'h0010), {16'h8000, 16'd0, 4'b0001});
    chk("pin_xor", ref_alu(3'd4, 16'hFFFF, 16'hFFFF), {16'h0000, 16'd0, 4'b0010});

    step();
    chk_en = 1;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", in_ready, 1'b1);
    chk("post_reset_valid", out_valid, 1'b0);
    chk("post_reset_out", {out, out_hi, flag_c, flag_v, flag_z, flag_n}, 36'd0);

    // Directed single-cycle ops
    step(); issue(3'd0, 16'd24050, 16'd53040); @(negedge clk);
    chk("add_valid", out_valid, 1'b1);
    chk("add_res", {out, out_hi, flag_c, flag_v, flag_z, flag_n}, {16'd11554, 16'd0, 4'b1000});
    step(); issue(3'd1, 16'd24050, 16'd53040); @(negedge clk);
    chk("sub_res", {out, out_hi, flag_c, flag_v, flag_z, flag_n}, {16'd36546, 16'd0, 4'b1101});
    step(); issue(3'd2, 16'd24050, 16'd53040); @(negedge clk);
    chk("and_res", out, 16'd19760);
    step(); issue(3'd4, 16'hFFFF, 16'hFFFF); @(negedge clk);
    chk("xor_res", {out, flag_z}, {16'd0, 1'b1});

    // Multi-cycle multiply: 16 cycles not ready, then the product
    step(); issue(3'd7, 16'd24050, 16'd53040);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("mul_busy_ready", in_ready, 1'b0);
      step();
    end
    @(negedge clk);
    chk("mul_valid", out_valid, 1'b1);
    chk("mul_res", {out_hi, out}, {16'd19464, 16'd19296});

    // Back-pressure: only the first of the queued ADDs goes in
    step();
    out_ready = 1'b0; in_valid = 1'b1; func = 3'd0; a = 16'd1; b = 16'd2;
    @(negedge clk);
    chk("bp_first_ready", in_ready, 1'b1);
    step();
    a = 16'd5; b = 16'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall_ready", in_ready, 1'b0);
      chk("bp_stall_out", {out_valid, out}, {1'b1, 16'd3});
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drain_accept", {out_valid, out}, {1'b1, 16'd11});

    // Reset in the middle of a multiply
    step(); issue(3'd7, 16'd24050, 16'd53040);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midmul_rst_valid", out_valid, 1'b0);
    chk("midmul_rst_ready", in_ready, 1'b1);
    chk("midmul_rst_out", {out, out_hi, flag_c, flag_v, flag_z, flag_n}, 36'd0);
    step(); issue(3'd0, 16'd24050, 16'd53040); @(negedge clk);
    chk("post_rst_add", {out_valid, out, flag_c}, {1'b1, 16'd11554, 1'b1});

    // Randomized traffic; the source holds an op until it is accepted
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || m_acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        func = 3'($urandom_range(0, 7));
        a = pick();
        b = pick();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (W + 4) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
